// File: rtl/aes_pkg.sv
// Shared AES output-path definitions.
//   AES_BLOCK_W / AES_WORD_W : default block and bus word widths
//   aes_block_t              : one AES result block
//   word_order_e             : order in which a block's words leave the serializer
//   ser_state_e              : serializer FSM states
//   word_slot()              : maps emission index -> word slot inside the block
package aes_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_WORD_W  = 32;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  typedef enum logic {
    LSW_FIRST = 1'b0,
    MSW_FIRST = 1'b1
  } word_order_e;

  typedef enum logic {
    SER_IDLE   = 1'b0,
    SER_STREAM = 1'b1
  } ser_state_e;

  // Emission index k selects bits [slot*WORD_W +: WORD_W] of the block.
  function automatic int unsigned word_slot(int unsigned k, int unsigned nwords,
                                            word_order_e order);
    return (order == MSW_FIRST) ? (nwords - 1 - k) : k;
  endfunction
endpackage

// File: rtl/aes_output_serializer_if.sv
// Handshake bundle between the AES core, the serializer and the output consumer.
//   in_valid/in_ready/text_in            : block push side (core -> buffer)
//   out_valid/out_ready/text_o           : word pop side (buffer -> consumer)
//   out_last/out_idx                     : position of the current word in its block
//   level                                : blocks held, including the one streaming
// slave  = serializer view, master = environment view.
interface aes_output_serializer_if #(
  parameter int BLOCK_W = 128,
  parameter int WORD_W  = 32,
  parameter int DEPTH   = 2
);
  localparam int NWORDS = BLOCK_W / WORD_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] text_in;
  logic               out_valid;
  logic               out_ready;
  logic [WORD_W-1:0]  text_o;
  logic               out_last;
  logic [IDX_W-1:0]   out_idx;
  logic [LVL_W-1:0]   level;

  modport master (
    output in_valid, text_in, out_ready,
    input  in_ready, out_valid, text_o, out_last, out_idx, level
  );

  modport slave (
    input  in_valid, text_in, out_ready,
    output in_ready, out_valid, text_o, out_last, out_idx, level
  );
endinterface

// File: rtl/aes_block_fifo.sv
// Whole-block circular buffer for the output serializer.
//   clk, rst (async active-low), i_clr (sync clear, wins over push/pop)
//   i_push/i_wdata : store a block at the write pointer (caller checks o_full)
//   i_pop          : release the head block (caller checks o_empty)
//   o_rdata        : head block, o_level : blocks held, o_full/o_empty flags
// Pointers wrap explicitly at DEPTH-1, so any DEPTH >= 1 works.
module aes_block_fifo
  import aes_pkg::*;
#(
  parameter int BLOCK_W = AES_BLOCK_W,
  parameter int DEPTH   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_clr,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [BLOCK_W-1:0]           i_wdata,
  output logic [BLOCK_W-1:0]           o_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  output logic                         o_full,
  output logic                         o_empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [BLOCK_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr, r_rptr;
  logic [LVL_W-1:0]   r_level;
  logic               w_push, w_pop;

  function automatic logic [PTR_W-1:0] ptr_next(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_push = i_push & ~i_clr;
  assign w_pop  = i_pop  & ~i_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_next(r_wptr);
      if (w_pop)  r_rptr <= ptr_next(r_rptr);
      // Push and pop together leave the level unchanged.
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_level = r_level;
  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);
endmodule

// File: rtl/aes_output_serializer.sv
// Buffers completed AES blocks and streams each as BLOCK_W/WORD_W words.
//   clk, rst (async active-low), clr (sync clear of buffer and partial stream)
//   bus (slave modport): block push handshake, word pop handshake,
//                        out_last/out_idx position info and buffer level.
// The block buffer lives in aes_block_fifo; this level holds the serializer
// FSM, the word counter and the word mux.
module aes_output_serializer #(
  parameter int BLOCK_W   = aes_pkg::AES_BLOCK_W,
  parameter int WORD_W    = aes_pkg::AES_WORD_W,
  parameter int DEPTH     = 2,
  parameter int MSW_FIRST = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  aes_output_serializer_if.slave  bus
);
  import aes_pkg::*;

  localparam int NWORDS = BLOCK_W / WORD_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam word_order_e ORDER = (MSW_FIRST != 0) ? aes_pkg::MSW_FIRST
                                                   : aes_pkg::LSW_FIRST;

  generate
    if ((BLOCK_W % WORD_W) != 0 || NWORDS < 2 || DEPTH < 1) begin : g_bad_cfg
      $error("aes_output_serializer: need BLOCK_W %% WORD_W == 0, NWORDS >= 2, DEPTH >= 1");
    end
  endgenerate

  ser_state_e         r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_slot;
  logic [BLOCK_W-1:0] w_head;
  logic [LVL_W-1:0]   w_level;
  logic               w_full, w_empty;
  logic               w_in_ready, w_push;
  logic               w_out_valid, w_fire, w_last, w_pop_blk;

  // in_ready comes from registered level only: a block freed this cycle
  // cannot be refilled in the same cycle.
  assign w_in_ready  = ~w_full;
  assign w_push      = bus.in_valid & w_in_ready & ~clr;
  assign w_out_valid = (r_state == SER_STREAM);
  assign w_fire      = w_out_valid & bus.out_ready;
  assign w_last      = (r_idx == IDX_W'(NWORDS - 1));
  assign w_pop_blk   = w_fire & w_last;

  aes_block_fifo #(
    .BLOCK_W (BLOCK_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (clr),
    .i_push  (w_push),
    .i_pop   (w_pop_blk),
    .i_wdata (bus.text_in),
    .o_rdata (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= SER_IDLE;
    else      r_state <= w_state_nxt;
  end

  // STREAM tracks "buffer non-empty"; leaving it only when the last block's
  // last word goes and nothing replaces it keeps back-to-back blocks bubble-free.
  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = SER_IDLE;
    end else begin
      unique case (r_state)
        SER_IDLE:   if (w_push) w_state_nxt = SER_STREAM;
        SER_STREAM: if (w_pop_blk && w_level == LVL_W'(1) && !w_push)
                      w_state_nxt = SER_IDLE;
        default:    w_state_nxt = SER_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_idx <= '0;
    else if (clr)    r_idx <= '0;
    else if (w_fire) r_idx <= w_last ? '0 : r_idx + 1'b1;
  end

  assign w_slot = IDX_W'(word_slot(int'(r_idx), NWORDS, ORDER));

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.text_o    = w_out_valid ? w_head[w_slot*WORD_W +: WORD_W] : '0;
  assign bus.out_last  = w_out_valid & w_last;
  assign bus.out_idx   = r_idx;
  assign bus.level     = w_level;

  logic w_unused;
  assign w_unused = w_empty;
endmodule

// File: tb/tb_aes_output_serializer.sv
module tb_aes_output_serializer;
  localparam int BW = 128;
  localparam int WW = 32;
  localparam int NW = BW / WW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           clr = 1'b0;
  logic           iv  = 1'b0;
  logic           ordy = 1'b0;
  logic [BW-1:0]  tin = '0;

  always #5 clk = ~clk;

  aes_output_serializer_if #(.BLOCK_W(BW), .WORD_W(WW), .DEPTH(2)) bus0();
  aes_output_serializer_if #(.BLOCK_W(BW), .WORD_W(WW), .DEPTH(3)) bus1();

  assign bus0.in_valid  = iv;
  assign bus0.text_in   = tin;
  assign bus0.out_ready = ordy;
  assign bus1.in_valid  = iv;
  assign bus1.text_in   = tin;
  assign bus1.out_ready = ordy;

  // dut0: LSW first, DEPTH 2; dut1: MSW first, DEPTH 3 (non power of 2)
  aes_output_serializer #(.BLOCK_W(BW), .WORD_W(WW), .DEPTH(2), .MSW_FIRST(0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .bus(bus0));
  aes_output_serializer #(.BLOCK_W(BW), .WORD_W(WW), .DEPTH(3), .MSW_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .bus(bus1));

  logic        ov  [2];
  logic        rdy [2];
  logic        lst [2];
  logic [31:0] txt [2];
  logic [1:0]  oix [2];
  logic [1:0]  lvl [2];

  assign ov[0] = bus0.out_valid;  assign ov[1] = bus1.out_valid;
  assign rdy[0] = bus0.in_ready;  assign rdy[1] = bus1.in_ready;
  assign lst[0] = bus0.out_last;  assign lst[1] = bus1.out_last;
  assign txt[0] = bus0.text_o;    assign txt[1] = bus1.text_o;
  assign oix[0] = bus0.out_idx;   assign oix[1] = bus1.out_idx;
  assign lvl[0] = bus0.level;     assign lvl[1] = bus1.level;

  // Reference model: a queue of whole blocks plus the emission index of the head.
  logic [BW-1:0] mq [2][$];
  int            midx   [2];
  int            mdepth [2] = '{2, 3};
  int            mmsw   [2] = '{0, 1};

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] word_of(logic [BW-1:0] b, int k, int msw);
    int            s;
    logic [BW-1:0] t;
    s = msw ? (NW - 1 - k) : k;
    t = b >> (s * WW);
    return t[31:0];
  endfunction

  task automatic chk(string nm, logic [BW-1:0] act, logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      midx[k] = 0;
    end
  endtask

  // One rising edge of the intended behaviour, using the inputs held before it.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int  pre;
      bit  push;
      if (clr) begin
        mq[k].delete();
        midx[k] = 0;
      end else begin
        pre  = mq[k].size();
        push = iv && (pre != mdepth[k]);
        if (pre != 0 && ordy) begin
          midx[k]++;
          if (midx[k] == NW) begin
            midx[k] = 0;
            void'(mq[k].pop_front());
          end
        end
        if (push) mq[k].push_back(tin);
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      int  sz;
      bit  ev;
      sz = mq[k].size();
      ev = (sz != 0);
      chk($sformatf("d%0d out_valid", k), BW'(ov[k]), BW'(ev));
      chk($sformatf("d%0d in_ready", k), BW'(rdy[k]), BW'(sz != mdepth[k]));
      chk($sformatf("d%0d level", k), BW'(lvl[k]), BW'(sz));
      chk($sformatf("d%0d text_o", k), BW'(txt[k]),
          ev ? BW'(word_of(mq[k][0], midx[k], mmsw[k])) : '0);
      chk($sformatf("d%0d out_last", k), BW'(lst[k]), BW'(ev && midx[k] == NW - 1));
      chk($sformatf("d%0d out_idx", k), BW'(oix[k]), BW'(midx[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  logic [BW-1:0] blk0;
  logic [31:0]   lit_lsw [4];
  logic [31:0]   lit_msw [4];

  initial begin
    blk0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    lit_lsw = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
    lit_msw = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};

    // Reset state
    #1 rst = 1'b0;
    model_clear();
    repeat (2) step();
    chk("reset in_ready", BW'(rdy[0]), BW'(1));
    chk("reset out_valid", BW'(ov[0]), BW'(0));
    chk("reset level", BW'(lvl[0]), BW'(0));
    rst = 1'b1;
    step();

    // Single block, LSW and MSW order, full-rate drain
    iv = 1'b1; tin = blk0; ordy = 1'b1;
    step();
    iv = 1'b0;
    for (int w = 0; w < NW; w++) begin
      if (w > 0) step();
      chk($sformatf("lit lsw word%0d", w), BW'(txt[0]), BW'(lit_lsw[w]));
      chk($sformatf("lit msw word%0d", w), BW'(txt[1]), BW'(lit_msw[w]));
      chk($sformatf("lit msw idx%0d", w), BW'(oix[1]), BW'(w));
      chk($sformatf("lit last%0d", w), BW'(lst[0]), BW'(w == NW - 1));
    end
    step();
    chk("lit idle after block", BW'(ov[0]), BW'(0));

    // Fill under backpressure, third push refused by the depth-2 instance
    ordy = 1'b0; iv = 1'b1;
    tin = {4{32'hA0A0_0001}}; step();
    tin = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0; step();
    chk("lit full level", BW'(lvl[0]), BW'(2));
    chk("lit full in_ready", BW'(rdy[0]), BW'(0));
    tin = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0; step();
    iv = 1'b0; ordy = 1'b1;
    repeat (14) step();

    // Stalls in the middle of a block
    iv = 1'b1; tin = {$urandom(), $urandom(), $urandom(), $urandom()}; ordy = 1'b0;
    step();
    iv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ordy = (i % 2 == 0);
      step();
    end
    ordy = 1'b1;
    repeat (6) step();

    // Push held while the full buffer pops its head's last word
    ordy = 1'b0; iv = 1'b1;
    tin = {4{32'h1111_AAAA}}; step();
    tin = {4{32'h2222_BBBB}}; step();
    tin = {4{32'h3333_CCCC}}; ordy = 1'b1;
    repeat (NW) step();
    chk("lit push rejected level", BW'(lvl[0]), BW'(1));
    iv = 1'b0;
    repeat (12) step();

    // Async reset in the middle of a block
    iv = 1'b1; tin = {$urandom(), $urandom(), $urandom(), $urandom()}; ordy = 1'b1;
    step();
    iv = 1'b0;
    step(); step();
    #2 rst = 1'b0;
    model_clear();
    #1 compare_all();
    chk("lit rst out_valid", BW'(ov[0]), BW'(0));
    chk("lit rst level", BW'(lvl[0]), BW'(0));
    step();
    rst = 1'b1;
    step();
    iv = 1'b1; tin = {$urandom(), $urandom(), $urandom(), $urandom()};
    step();
    iv = 1'b0;
    chk("lit idx after rst", BW'(oix[0]), BW'(0));
    step();

    // Synchronous clear with a push in the same cycle
    clr = 1'b1; iv = 1'b1; tin = {$urandom(), $urandom(), $urandom(), $urandom()};
    step();
    clr = 1'b0; iv = 1'b0;
    chk("lit clr out_valid", BW'(ov[0]), BW'(0));
    chk("lit clr level", BW'(lvl[1]), BW'(0));
    iv = 1'b1; tin = {$urandom(), $urandom(), $urandom(), $urandom()};
    step();
    iv = 1'b0;
    chk("lit idx after clr", BW'(oix[1]), BW'(0));
    repeat (5) step();

    // Random traffic
    repeat (800) begin
      iv   = ($urandom_range(0, 99) < 60);
      tin  = {$urandom(), $urandom(), $urandom(), $urandom()};
      ordy = ($urandom_range(0, 99) < 70);
      clr  = ($urandom_range(0, 99) < 2);
      step();
    end
    iv = 1'b0; clr = 1'b0; ordy = 1'b1;
    repeat (16) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
